// File: rtl/ring_fifo_ctrl.sv
// Head/tail/count controller for a synchronous FIFO over external storage of any depth.
// Pointers wrap at NDATA-1, so non-power-of-two depths never address past the last entry.
module ring_fifo_ctrl #(
    parameter int NDATA     = 4,
    parameter int AF_LVL    = NDATA - 1,
    parameter int AE_LVL    = 1,
    parameter bit FULL_PASS = 1'b1,
    localparam int ABW      = ($clog2(NDATA) > 0) ? $clog2(NDATA) : 1,
    localparam int CBW      = $clog2(NDATA + 1)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           src_rdy,
    output logic           src_ack,
    output logic           dst_rdy,
    input  logic           dst_ack,
    input  logic           i_flush,
    output logic           o_wen,
    output logic [ABW-1:0] o_waddr,
    output logic [ABW-1:0] o_raddr,
    output logic [CBW-1:0] o_count,
    output logic           o_almost_full,
    output logic           o_almost_empty
);

    logic [ABW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CBW-1:0] count_q, count_d;
    logic           full_s, empty_s, push_s, pop_s, cnt_en_s;

    function automatic logic [ABW-1:0] ptr_inc(input logic [ABW-1:0] ptr);
        if (ptr == ABW'(NDATA - 1)) begin
            ptr_inc = {ABW{1'b0}};
        end else begin
            ptr_inc = ptr + ABW'(1);
        end
    endfunction

    // Handshakes: src_ack is held low while reset is asserted so it shows its reset value.
    always_comb begin
        full_s  = (count_q == CBW'(NDATA));
        empty_s = (count_q == {CBW{1'b0}});
        dst_rdy = !empty_s && !i_flush;
        pop_s   = dst_ack && dst_rdy;
        if (FULL_PASS) begin
            src_ack = i_rst && src_rdy && !i_flush && (!full_s || pop_s);
        end else begin
            src_ack = i_rst && src_rdy && !i_flush && !full_s;
        end
        push_s = src_ack;
    end

    // Next-state pointers and occupancy; flush overrides any handshake.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        cnt_en_s = push_s ^ pop_s;
        if (i_flush) begin
            head_d   = {ABW{1'b0}};
            tail_d   = {ABW{1'b0}};
            count_d  = {CBW{1'b0}};
            cnt_en_s = 1'b1;
        end else begin
            if (push_s) begin
                tail_d = ptr_inc(tail_q);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = ptr_inc(head_q);
            end else begin
                head_d = head_q;
            end
            if (push_s && !pop_s) begin
                count_d = count_q + CBW'(1);
            end else if (pop_s && !push_s) begin
                count_d = count_q - CBW'(1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // State registers; count only loads when occupancy actually changes.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            head_q  <= {ABW{1'b0}};
            tail_q  <= {ABW{1'b0}};
            count_q <= {CBW{1'b0}};
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (cnt_en_s) begin
                count_q <= count_d;
            end else begin
                count_q <= count_q;
            end
        end
    end

    assign o_wen          = src_ack;
    assign o_waddr        = tail_q;
    assign o_raddr        = head_q;
    assign o_count        = count_q;
    assign o_almost_full  = (int'(count_q) >= AF_LVL);
    assign o_almost_empty = (int'(count_q) <= AE_LVL);

    ring_fifo_ctrl_chk #(
        .NDATA (NDATA),
        .AF_LVL(AF_LVL),
        .AE_LVL(AE_LVL),
        .ABW   (ABW),
        .CBW   (CBW)
    ) u_chk (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .head_q (head_q),
        .tail_q (tail_q),
        .count_q(count_q),
        .push_s (push_s),
        .pop_s  (pop_s)
    );

endmodule

// Invariant checks on the controller state; has no effect on the logic it observes.
module ring_fifo_ctrl_chk #(
    parameter int NDATA  = 4,
    parameter int AF_LVL = 3,
    parameter int AE_LVL = 1,
    parameter int ABW    = 2,
    parameter int CBW    = 3
) (
    input logic           i_clk,
    input logic           i_rst,
    input logic [ABW-1:0] head_q,
    input logic [ABW-1:0] tail_q,
    input logic [CBW-1:0] count_q,
    input logic           push_s,
    input logic           pop_s
);

    a_levels: assert property (@(posedge i_clk) (AF_LVL <= NDATA) && (AE_LVL < NDATA));

    a_count_max: assert property (@(posedge i_clk) disable iff (!i_rst)
        int'(count_q) <= NDATA);

    a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst)
        !(pop_s && (count_q == {CBW{1'b0}})));

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst)
        !(push_s && !pop_s && (int'(count_q) == NDATA)));

    a_ptr_count: assert property (@(posedge i_clk) disable iff (!i_rst)
        (int'(count_q) == ((int'(tail_q) - int'(head_q) + NDATA) % NDATA)) ||
        ((int'(count_q) == NDATA) && (tail_q == head_q)));

endmodule

// File: tb/tb_ring_fifo_ctrl.sv
// Directed bench for ring_fifo_ctrl: three instances (depth 4 pass-through, depth 4 strict, depth 3)
// with bench-side storage and queue scoreboards checking data order.
module tb_ring_fifo_ctrl;

    logic clk, rst;
    int   n_chk, n_fail;

    logic       s_rdy0, s_ack0, d_rdy0, d_ack0, fl0, wen0, af0, ae0;
    logic [1:0] waddr0, raddr0;
    logic [2:0] cnt0;
    logic       s_rdy1, s_ack1, d_rdy1, d_ack1, fl1, wen1, af1, ae1;
    logic [1:0] waddr1, raddr1;
    logic [2:0] cnt1;
    logic       s_rdy2, s_ack2, d_rdy2, d_ack2, fl2, wen2, af2, ae2;
    logic [1:0] waddr2, raddr2;
    logic [1:0] cnt2;

    logic [7:0] wd0, wd2;
    logic [7:0] mem0 [0:3];
    logic [7:0] mem2 [0:3];
    logic [7:0] q0[$];
    logic [7:0] q2[$];

    ring_fifo_ctrl #(.NDATA(4), .FULL_PASS(1'b1)) dut0 (
        .i_clk(clk), .i_rst(rst), .src_rdy(s_rdy0), .src_ack(s_ack0), .dst_rdy(d_rdy0),
        .dst_ack(d_ack0), .i_flush(fl0), .o_wen(wen0), .o_waddr(waddr0), .o_raddr(raddr0),
        .o_count(cnt0), .o_almost_full(af0), .o_almost_empty(ae0));

    ring_fifo_ctrl #(.NDATA(4), .FULL_PASS(1'b0)) dut1 (
        .i_clk(clk), .i_rst(rst), .src_rdy(s_rdy1), .src_ack(s_ack1), .dst_rdy(d_rdy1),
        .dst_ack(d_ack1), .i_flush(fl1), .o_wen(wen1), .o_waddr(waddr1), .o_raddr(raddr1),
        .o_count(cnt1), .o_almost_full(af1), .o_almost_empty(ae1));

    ring_fifo_ctrl #(.NDATA(3), .FULL_PASS(1'b1)) dut2 (
        .i_clk(clk), .i_rst(rst), .src_rdy(s_rdy2), .src_ack(s_ack2), .dst_rdy(d_rdy2),
        .dst_ack(d_ack2), .i_flush(fl2), .o_wen(wen2), .o_waddr(waddr2), .o_raddr(raddr2),
        .o_count(cnt2), .o_almost_full(af2), .o_almost_empty(ae2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Storage model and scoreboard for the depth-4 instance.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q0.delete();
        end else if (fl0) begin
            q0.delete();
        end else begin
            if (wen0) begin
                mem0[waddr0] <= wd0;
                q0.push_back(wd0);
            end
            if (d_ack0 && d_rdy0) begin
                chk("sb0_nonempty", 32'(q0.size() > 0), 32'd1);
                if (q0.size() > 0) chk("sb0_data", 32'(mem0[raddr0]), 32'(q0.pop_front()));
            end
        end
    end

    // Storage model and scoreboard for the depth-3 instance.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q2.delete();
        end else begin
            if (wen2) begin
                mem2[waddr2] <= wd2;
                q2.push_back(wd2);
            end
            if (d_ack2 && d_rdy2) begin
                chk("sb2_nonempty", 32'(q2.size() > 0), 32'd1);
                if (q2.size() > 0) chk("sb2_data", 32'(mem2[raddr2]), 32'(q2.pop_front()));
            end
        end
    end

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b0;
        {s_rdy0, d_ack0, fl0, s_rdy1, d_ack1, fl1, s_rdy2, d_ack2, fl2} = '0;
        wd0 = 8'h00; wd2 = 8'h00;
        #3;
        chk("rst_cnt", 32'(cnt0), 32'd0);
        chk("rst_dst_rdy", 32'(d_rdy0), 32'd0);
        chk("rst_src_ack", 32'(s_ack0), 32'd0);
        chk("rst_ae", 32'(ae0), 32'd1);
        chk("rst_af", 32'(af0), 32'd0);
        #9 rst = 1'b1;
        cyc();

        // Fill depth-4 FIFO with no consumer.
        s_rdy0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wd0 = 8'hA0 + 8'(i);
            #1;
            chk("fill_src_ack", 32'(s_ack0), 32'd1);
            chk("fill_wen", 32'(wen0), 32'd1);
            chk("fill_waddr", 32'(waddr0), 32'(i));
            chk("fill_cnt", 32'(cnt0), 32'(i));
            chk("fill_af", 32'(af0), 32'(i >= 3));
            cyc();
        end
        #1;
        chk("full_src_ack", 32'(s_ack0), 32'd0);
        chk("full_cnt", 32'(cnt0), 32'd4);
        chk("full_waddr_wrap", 32'(waddr0), 32'd0);
        chk("full_af", 32'(af0), 32'd1);
        chk("full_dst_rdy", 32'(d_rdy0), 32'd1);

        // Full with push and pop in the same cycle: pass-through.
        d_ack0 = 1'b1; wd0 = 8'hE4;
        #1;
        chk("fp1_src_ack", 32'(s_ack0), 32'd1);
        chk("fp1_raddr", 32'(raddr0), 32'd0);
        cyc();
        s_rdy0 = 1'b0;
        chk("fp1_cnt", 32'(cnt0), 32'd4);
        chk("fp1_raddr_adv", 32'(raddr0), 32'd1);
        chk("fp1_waddr_adv", 32'(waddr0), 32'd1);

        // Drain; data order is checked by the scoreboard.
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("drain_cnt", 32'(cnt0), 32'(3 - i));
        end
        chk("drain_dst_rdy", 32'(d_rdy0), 32'd0);
        chk("drain_ae", 32'(ae0), 32'd1);

        // Pop request while empty is ignored.
        cyc();
        chk("empty_ack_raddr", 32'(raddr0), 32'd1);
        chk("empty_ack_cnt", 32'(cnt0), 32'd0);
        d_ack0 = 1'b0;

        // First push into empty FIFO: dst_rdy rises one cycle later.
        s_rdy0 = 1'b1; wd0 = 8'hB0;
        #1;
        chk("nobypass_dst_rdy", 32'(d_rdy0), 32'd0);
        cyc();
        wd0 = 8'hB1;
        chk("first_dst_rdy", 32'(d_rdy0), 32'd1);
        chk("first_cnt", 32'(cnt0), 32'd1);
        cyc();
        chk("pre_flush_cnt", 32'(cnt0), 32'd2);

        // Flush with both handshakes requested.
        fl0 = 1'b1; d_ack0 = 1'b1;
        #1;
        chk("flush_src_ack", 32'(s_ack0), 32'd0);
        chk("flush_dst_rdy", 32'(d_rdy0), 32'd0);
        cyc();
        fl0 = 1'b0; s_rdy0 = 1'b0; d_ack0 = 1'b0;
        #1;
        chk("flush_cnt", 32'(cnt0), 32'd0);
        chk("flush_raddr", 32'(raddr0), 32'd0);
        chk("flush_waddr", 32'(waddr0), 32'd0);
        chk("flush_ae", 32'(ae0), 32'd1);

        // Strict mode: full with push and pop requested pops only.
        s_rdy1 = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("fp0_cnt_full", 32'(cnt1), 32'd4);
        d_ack1 = 1'b1;
        #1;
        chk("fp0_src_ack", 32'(s_ack1), 32'd0);
        chk("fp0_dst_rdy", 32'(d_rdy1), 32'd1);
        cyc();
        s_rdy1 = 1'b0; d_ack1 = 1'b0;
        chk("fp0_cnt", 32'(cnt1), 32'd3);
        chk("fp0_raddr", 32'(raddr1), 32'd1);
        chk("fp0_waddr", 32'(waddr1), 32'd0);

        // Depth-3: prefill one, then 10 push/pop pairs; pointers cycle 0,1,2.
        s_rdy2 = 1'b1; wd2 = 8'h10;
        cyc();
        d_ack2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wd2 = 8'h11 + 8'(i);
            #1;
            chk("n3_src_ack", 32'(s_ack2), 32'd1);
            chk("n3_waddr", 32'(waddr2), 32'((i + 1) % 3));
            chk("n3_raddr", 32'(raddr2), 32'(i % 3));
            cyc();
        end
        s_rdy2 = 1'b0; d_ack2 = 1'b0;
        chk("n3_cnt", 32'(cnt2), 32'd1);
        chk("n3_ae", 32'(ae2), 32'd1);
        chk("n3_af", 32'(af2), 32'd0);

        // Asynchronous reset with three entries held.
        s_rdy0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wd0 = 8'hC0 + 8'(i);
            cyc();
        end
        s_rdy0 = 1'b0;
        chk("prerst_cnt", 32'(cnt0), 32'd3);
        chk("prerst_waddr", 32'(waddr0), 32'd3);
        rst = 1'b0;
        #1;
        chk("arst_cnt", 32'(cnt0), 32'd0);
        chk("arst_waddr", 32'(waddr0), 32'd0);
        chk("arst_raddr", 32'(raddr0), 32'd0);
        chk("arst_dst_rdy", 32'(d_rdy0), 32'd0);
        chk("arst_ae", 32'(ae0), 32'd1);
        rst = 1'b1;
        cyc();
        s_rdy0 = 1'b1; wd0 = 8'hD0;
        #1;
        chk("postrst_src_ack", 32'(s_ack0), 32'd1);
        chk("postrst_waddr", 32'(waddr0), 32'd0);
        cyc();
        s_rdy0 = 1'b0;
        chk("postrst_cnt", 32'(cnt0), 32'd1);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
